// File: rtl/store_commit_queue_if.sv
// Store-unit / commit / memory-write signal bundle for store_commit_queue.
interface store_commit_queue_if #(
   parameter int unsigned PLEN = 34,
   parameter int unsigned XLEN = 32
);
   logic                flush_i;
   logic                valid_i;
   logic [PLEN-1:0]     paddr_i;
   logic [XLEN-1:0]     data_i;
   logic [XLEN/8-1:0]   be_i;
   logic                ready_o;
   logic                commit_i;
   logic                commit_ready_o;
   logic                req_o;
   logic [PLEN-1:0]     req_addr_o;
   logic [XLEN-1:0]     req_data_o;
   logic [XLEN/8-1:0]   req_be_o;
   logic                gnt_i;
   logic                no_st_pending_o;
   logic [11:0]         page_offset_i;
   logic                page_offset_matches_o;

   modport slave (
      input  flush_i, valid_i, paddr_i, data_i, be_i, commit_i, gnt_i, page_offset_i,
      output ready_o, commit_ready_o, req_o, req_addr_o, req_data_o, req_be_o,
             no_st_pending_o, page_offset_matches_o
   );

   modport master (
      output flush_i, valid_i, paddr_i, data_i, be_i, commit_i, gnt_i, page_offset_i,
      input  ready_o, commit_ready_o, req_o, req_addr_o, req_data_o, req_be_o,
             no_st_pending_o, page_offset_matches_o
   );
endinterface

// File: rtl/store_commit_queue.sv
// Two-stage store buffer: speculative FIFO feeding a committed FIFO that drains to memory.
// Define STORE_COMMIT_QUEUE_FWD_EN to enable the load page-offset hazard comparators.
module store_commit_queue #(
   parameter int unsigned SPEC_DEPTH   = 4,
   parameter int unsigned COMMIT_DEPTH = 8,
   parameter int unsigned PLEN         = 34,
   parameter int unsigned XLEN         = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   store_commit_queue_if.slave  bus
);
   localparam int unsigned SAW = $clog2(SPEC_DEPTH);
   localparam int unsigned CAW = $clog2(COMMIT_DEPTH);
   localparam logic [SAW:0] SPEC_FULL   = (SAW+1)'(SPEC_DEPTH);
   localparam logic [CAW:0] COMMIT_FULL = (CAW+1)'(COMMIT_DEPTH);

   typedef struct packed {
      logic [PLEN-1:0]   paddr;
      logic [XLEN-1:0]   data;
      logic [XLEN/8-1:0] be;
   } st_entry_t;

   st_entry_t spec_mem_q   [SPEC_DEPTH];
   st_entry_t commit_mem_q [COMMIT_DEPTH];

   logic [SAW-1:0] spec_wptr_q, spec_wptr_d, spec_rptr_q, spec_rptr_d;
   logic [SAW:0]   spec_cnt_q, spec_cnt_d;
   logic [CAW-1:0] commit_wptr_q, commit_wptr_d, commit_rptr_q, commit_rptr_d;
   logic [CAW:0]   commit_cnt_q, commit_cnt_d;

   logic push, commit, pop;

   assign bus.ready_o         = (spec_cnt_q != SPEC_FULL);
   assign bus.commit_ready_o  = (commit_cnt_q != COMMIT_FULL);
   assign bus.req_o           = (commit_cnt_q != '0);
   assign bus.req_addr_o      = commit_mem_q[commit_rptr_q].paddr;
   assign bus.req_data_o      = commit_mem_q[commit_rptr_q].data;
   assign bus.req_be_o        = commit_mem_q[commit_rptr_q].be;
   assign bus.no_st_pending_o = (spec_cnt_q == '0) && (commit_cnt_q == '0);

   assign push   = bus.valid_i && bus.ready_o && !bus.flush_i;
   assign commit = bus.commit_i && (spec_cnt_q != '0) && bus.commit_ready_o;
   assign pop    = bus.req_o && bus.gnt_i;

   always_comb begin
      spec_wptr_d   = spec_wptr_q;
      spec_rptr_d   = spec_rptr_q;
      spec_cnt_d    = spec_cnt_q;
      commit_wptr_d = commit_wptr_q;
      commit_rptr_d = commit_rptr_q;
      commit_cnt_d  = commit_cnt_q;

      if (push)   spec_wptr_d = spec_wptr_q + SAW'(1);
      if (commit) spec_rptr_d = spec_rptr_q + SAW'(1);
      case ({push, commit})
         2'b10:   spec_cnt_d = spec_cnt_q + (SAW+1)'(1);
         2'b01:   spec_cnt_d = spec_cnt_q - (SAW+1)'(1);
         default: spec_cnt_d = spec_cnt_q;
      endcase
      // Flush wins over the spec-side update; the committing entry was already read out.
      if (bus.flush_i) begin
         spec_wptr_d = '0;
         spec_rptr_d = '0;
         spec_cnt_d  = '0;
      end

      if (commit) commit_wptr_d = commit_wptr_q + CAW'(1);
      if (pop)    commit_rptr_d = commit_rptr_q + CAW'(1);
      case ({commit, pop})
         2'b10:   commit_cnt_d = commit_cnt_q + (CAW+1)'(1);
         2'b01:   commit_cnt_d = commit_cnt_q - (CAW+1)'(1);
         default: commit_cnt_d = commit_cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         spec_wptr_q   <= '0;
         spec_rptr_q   <= '0;
         spec_cnt_q    <= '0;
         commit_wptr_q <= '0;
         commit_rptr_q <= '0;
         commit_cnt_q  <= '0;
      end else begin
         spec_wptr_q   <= spec_wptr_d;
         spec_rptr_q   <= spec_rptr_d;
         spec_cnt_q    <= spec_cnt_d;
         commit_wptr_q <= commit_wptr_d;
         commit_rptr_q <= commit_rptr_d;
         commit_cnt_q  <= commit_cnt_d;
      end
   end

   // Entry storage carries no reset; validity comes solely from the counts.
   always_ff @(posedge clk_i) begin
      if (push)   spec_mem_q[spec_wptr_q]     <= '{paddr: bus.paddr_i, data: bus.data_i, be: bus.be_i};
      if (commit) commit_mem_q[commit_wptr_q] <= spec_mem_q[spec_rptr_q];
   end

`ifdef STORE_COMMIT_QUEUE_FWD_EN
   logic           match;
   logic [SAW-1:0] s_off;
   logic [CAW-1:0] c_off;

   always_comb begin
      match = 1'b0;
      s_off = '0;
      c_off = '0;
      for (int i = 0; i < SPEC_DEPTH; i++) begin
         s_off = SAW'(i) - spec_rptr_q;
         if (({1'b0, s_off} < spec_cnt_q) &&
             (spec_mem_q[i].paddr[11:3] == bus.page_offset_i[11:3]))
            match = 1'b1;
      end
      for (int i = 0; i < COMMIT_DEPTH; i++) begin
         c_off = CAW'(i) - commit_rptr_q;
         if (({1'b0, c_off} < commit_cnt_q) &&
             (commit_mem_q[i].paddr[11:3] == bus.page_offset_i[11:3]))
            match = 1'b1;
      end
   end

   assign bus.page_offset_matches_o = match;
`else
   assign bus.page_offset_matches_o = 1'b0;
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// Scoreboard bench for store_commit_queue: queue model checked every negedge.
module tb_store_commit_queue;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   typedef struct {
      logic [33:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } st_t;

   st_t mspec[$];
   st_t sb[$];

   store_commit_queue_if #(.PLEN(34), .XLEN(32)) bus();

   store_commit_queue #(
      .SPEC_DEPTH(4), .COMMIT_DEPTH(8), .PLEN(34), .XLEN(32)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic pom_model();
      logic m;
      m = 1'b0;
`ifdef STORE_COMMIT_QUEUE_FWD_EN
      foreach (mspec[i]) if (mspec[i].a[11:3] == bus.page_offset_i[11:3]) m = 1'b1;
      foreach (sb[i])    if (sb[i].a[11:3]    == bus.page_offset_i[11:3]) m = 1'b1;
`endif
      return m;
   endfunction

   // Model: check outputs against current state, then apply this cycle's inputs.
   always @(negedge clk_i) begin
      logic do_push, do_commit, do_pop;
      st_t  e;
      if (!rst_ni) begin
         mspec.delete();
         sb.delete();
      end
      chk("ready",   bus.ready_o,               mspec.size() != 4);
      chk("cready",  bus.commit_ready_o,        sb.size() != 8);
      chk("req",     bus.req_o,                 sb.size() != 0);
      chk("nsp",     bus.no_st_pending_o,       (mspec.size() == 0) && (sb.size() == 0));
      chk("pom",     bus.page_offset_matches_o, pom_model());
      if (rst_ni) begin
         do_push   = bus.valid_i && (mspec.size() != 4) && !bus.flush_i;
         do_commit = bus.commit_i && (mspec.size() != 0) && (sb.size() != 8);
         do_pop    = (sb.size() != 0) && bus.gnt_i;
         if (do_pop) begin
            e = sb.pop_front();
            chk("addr", bus.req_addr_o, e.a);
            chk("data", bus.req_data_o, e.d);
            chk("be",   bus.req_be_o,   e.be);
         end
         if (do_commit) sb.push_back(mspec.pop_front());
         if (bus.flush_i) mspec.delete();
         if (do_push) begin
            e.a  = bus.paddr_i;
            e.d  = bus.data_i;
            e.be = bus.be_i;
            mspec.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push1(input logic [33:0] a);
      bus.valid_i = 1'b1;
      bus.paddr_i = a;
      bus.data_i  = $urandom;
      bus.be_i    = 4'($urandom_range(1, 15));
      step();
      bus.valid_i = 1'b0;
   endtask

   task automatic commit1();
      bus.commit_i = 1'b1;
      step();
      bus.commit_i = 1'b0;
   endtask

   task automatic drain();
      bus.commit_i = 1'b1;
      bus.gnt_i    = 1'b1;
      repeat (14) step();
      bus.commit_i = 1'b0;
      bus.gnt_i    = 1'b0;
      @(negedge clk_i);
      chk("drain_nsp", bus.no_st_pending_o, 1'b1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [33:0] pa, pb;
      logic        fwd;
`ifdef STORE_COMMIT_QUEUE_FWD_EN
      fwd = 1'b1;
`else
      fwd = 1'b0;
`endif
      bus.flush_i = 0; bus.valid_i = 0; bus.paddr_i = '0; bus.data_i = '0; bus.be_i = '0;
      bus.commit_i = 0; bus.gnt_i = 0; bus.page_offset_i = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Fill spec queue; fifth push is dropped
      for (int k = 0; k < 5; k++) push1(34'h080000000 + 34'(4 * k));
      @(negedge clk_i);
      chk("full_ready", bus.ready_o, 1'b0);
      step();
      drain();

      // Two committed stores held by a slow grant
      pa = 34'h080001000;
      pb = 34'h080001004;
      push1(pa);
      push1(pb);
      commit1();
      commit1();
      repeat (3) begin
         @(negedge clk_i);
         chk("hold_addr", bus.req_addr_o, pa);
         step();
      end
      bus.gnt_i = 1'b1;
      step();
      @(negedge clk_i);
      chk("next_addr", bus.req_addr_o, pb);
      step();
      bus.gnt_i = 1'b0;
      @(negedge clk_i);
      chk("ab_nsp", bus.no_st_pending_o, 1'b1);
      step();

      // Flush with a same-cycle commit keeps only the oldest entry
      for (int k = 0; k < 3; k++) push1(34'h080002000 + 34'(8 * k));
      bus.flush_i  = 1'b1;
      bus.commit_i = 1'b1;
      bus.valid_i  = 1'b1;
      step();
      bus.flush_i = 1'b0; bus.commit_i = 1'b0; bus.valid_i = 1'b0;
      @(negedge clk_i);
      chk("flush_req", bus.req_o, 1'b1);
      step();
      bus.gnt_i = 1'b1;
      step();
      bus.gnt_i = 1'b0;
      @(negedge clk_i);
      chk("flush_nsp", bus.no_st_pending_o, 1'b1);
      step();

      // Committed queue full: further commit is ignored
      for (int k = 0; k < 8; k++) begin
         push1(34'h080003000 + 34'(8 * k));
         commit1();
      end
      push1(34'h080003100);
      commit1();
      @(negedge clk_i);
      chk("cq_full_cready", bus.commit_ready_o, 1'b0);
      chk("cq_full_nsp",    bus.no_st_pending_o, 1'b0);
      step();
      drain();

      // Reset while requests are pending
      for (int k = 0; k < 5; k++) begin
         push1(34'h080004000 + 34'(8 * k));
         commit1();
      end
      @(posedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      chk("rst_req", bus.req_o, 1'b0);
      chk("rst_nsp", bus.no_st_pending_o, 1'b1);
      bus.gnt_i = 1'b1;
      step();
      step();
      rst_ni = 1'b1;
      repeat (3) step();
      bus.gnt_i = 1'b0;

      // Page-offset hazard check in both queues
      push1(34'h080000A48);
      bus.page_offset_i = 12'hA4C;
      #1 chk("pom_spec_hit", bus.page_offset_matches_o, fwd);
      bus.page_offset_i = 12'hA50;
      #1 chk("pom_spec_miss", bus.page_offset_matches_o, 1'b0);
      commit1();
      bus.page_offset_i = 12'hA4C;
      #1 chk("pom_cq_hit", bus.page_offset_matches_o, fwd);
      step();
      drain();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         bus.valid_i       = 1'($urandom_range(0, 1));
         bus.paddr_i       = 34'h080000000 | 34'($urandom_range(0, 63) << 3);
         bus.data_i        = $urandom;
         bus.be_i          = 4'($urandom_range(0, 15));
         bus.commit_i      = ($urandom_range(0, 2) == 0);
         bus.flush_i       = ($urandom_range(0, 15) == 0);
         bus.gnt_i         = ($urandom_range(0, 2) != 0);
         bus.page_offset_i = 12'($urandom_range(0, 63) << 3);
         step();
      end
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/store_commit_queue.md
STORE_COMMIT_QUEUE -- requirements
Module: store_commit_queue

Interface
REQ-001 SHALL have parameter SPEC_DEPTH, default 4, speculative-queue entries (power of two, >=2).
REQ-002 SHALL have parameter COMMIT_DEPTH, default 8, committed-queue entries (power of two, >=2).
REQ-003 SHALL have parameter PLEN, default 34, physical address width (Sv32).
REQ-004 SHALL have parameter XLEN, default 32, store data width.
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush_i  input  1  discard all speculative entries.
REQ-008 SHALL have port valid_i  input  1  store unit pushes a speculative store.
REQ-009 SHALL have port paddr_i  input  PLEN  store physical address.
REQ-010 SHALL have port data_i  input  XLEN  store data.
REQ-011 SHALL have port be_i  input  XLEN/8  byte enables.
REQ-012 SHALL have port ready_o  output  1  speculative queue not full.
REQ-013 SHALL have port commit_i  input  1  commit oldest speculative entry.
REQ-014 SHALL have port commit_ready_o  output  1  committed queue not full.
REQ-015 SHALL have port req_o  output  1  memory write request valid.
REQ-016 SHALL have port req_addr_o / req_data_o / req_be_o  output  PLEN / XLEN / XLEN/8  head of committed queue.
REQ-017 SHALL have port gnt_i  input  1  memory accepted the request.
REQ-018 SHALL have port no_st_pending_o  output  1  both queues empty.
REQ-019 SHALL have ports page_offset_i  input  12 and page_offset_matches_o  output  1  load-address hazard check.

Function
REQ-020 Push SHALL occur when valid_i && ready_o && !flush_i; entry visible to commit next cycle.
REQ-021 ready_o SHALL equal (spec count != SPEC_DEPTH), combinational from registered count; valid_i while full SHALL be dropped.
REQ-022 Commit SHALL occur when commit_i && spec count != 0 && commit_ready_o; otherwise commit_i is ignored with no state change.
REQ-023 Commit SHALL move the oldest speculative entry to the committed-queue tail; req_o for it asserts no earlier than next cycle.
REQ-024 commit_ready_o SHALL equal (commit count != COMMIT_DEPTH); a pop in the same cycle SHALL NOT make a full queue accept a commit.
REQ-025 req_o SHALL equal (commit count != 0); req_addr_o/data/be SHALL be stable while req_o && !gnt_i.
REQ-026 Pop SHALL occur on req_o && gnt_i; gnt_i with req_o low SHALL be ignored.
REQ-027 Simultaneous push and commit on spec queue, or commit and pop on commit queue, SHALL leave that count unchanged.
REQ-028 flush_i SHALL zero spec count and pointers next cycle; a same-cycle legal commit SHALL still transfer the oldest entry; same-cycle push SHALL be discarded; committed queue unaffected.
REQ-029 Read/write pointers SHALL wrap modulo depth; counts SHALL be depth-bit-plus-one wide.
REQ-030 no_st_pending_o SHALL equal (spec count == 0 && commit count == 0).

Reset
REQ-031 On rst_ni low, both counts and all pointers SHALL reset to 0 asynchronously; entry storage need not reset.
REQ-032 During reset SHALL output ready_o=1, commit_ready_o=1, req_o=0, no_st_pending_o=1, page_offset_matches_o=0; a reset mid-transfer SHALL drop all entries.

Configuration
REQ-033 Macro STORE_COMMIT_QUEUE_FWD_EN defined: page_offset_matches_o SHALL be 1 combinationally when any valid entry in either queue has paddr[11:3] == page_offset_i[11:3].
REQ-034 Macro undefined: page_offset_matches_o SHALL be tied 0, no comparators instantiated; all other behaviour identical.

Verification
REQ-035 Push 4 stores (paddr 0x8000_0000..0x8000_000C) with commit_i=0 -> ready_o=0 after 4th; 5th valid_i dropped; count stays 4.
REQ-036 Push A, B; commit both; gnt_i held low 3 cycles then high -> req_addr_o=A stable 3 cycles, then B next cycle, no_st_pending_o=1 after B granted.
REQ-037 Spec holds 3 entries; flush_i with commit_i same cycle -> exactly 1 entry on req_o, spec count 0.
REQ-038 Fill committed queue to 8, gnt_i=0, commit_i=1 -> commit ignored, spec count unchanged, commit_ready_o=0.
REQ-039 Assert rst_ni low while req_o=1 with 5 entries -> req_o=0 immediately, no_st_pending_o=1, no grant consumed after release.
REQ-040 FWD_EN defined, entry paddr 0x8000_0A48, page_offset_i=0xA4C -> page_offset_matches_o=1; 0xA50 -> 0; macro undefined -> always 0.
